// File: rtl/ahblite_dma_master_pkg.sv
// Shared bus encodings and state types for the AHB-Lite word-copy DMA.
// Used by ahblite_dma_master (optional DMA_IRQ_EN) and ahblite_master_if.
package ahblite_dma_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RA,
    S_RD,
    S_WA,
    S_WD,
    S_FIN
  } dma_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_ADDR,
    PH_DATA
  } bus_phase_e;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ahblite_master_if.sv
// Address/data-phase sequencer for one non-pipelined AHB-Lite transfer.
// A req loads a new address phase; ack marks the data phase completing.
module ahblite_master_if
  import ahblite_dma_master_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        aack,
  output logic        dack,
  output logic        derr_first,
  output logic        derr,
  output logic [31:0] rdata,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic [31:0] hrdata,
  input  logic        hresp
);

  bus_phase_e  phase_q, phase_d;
  logic [31:0] haddr_q, haddr_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] hwdata_q, hwdata_d;

  always_comb begin
    phase_d  = phase_q;
    haddr_d  = haddr_q;
    htrans_d = htrans_q;
    hwrite_d = hwrite_q;
    hwdata_d = hwdata_q;
    if (req) begin
      phase_d  = PH_ADDR;
      haddr_d  = addr;
      htrans_d = HTRANS_NONSEQ;
      hwrite_d = we;
    end else begin
      case (phase_q)
        PH_ADDR: begin
          if (hready) begin
            phase_d  = PH_DATA;
            htrans_d = HTRANS_IDLE;
            if (hwrite_q) hwdata_d = wdata;
          end
        end
        PH_DATA: begin
          if (hready) phase_d = PH_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= PH_IDLE;
      haddr_q  <= '0;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
    end else begin
      phase_q  <= phase_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
    end
  end

  // HADDR is held through the data phase so the error address is still visible
  assign aack       = (phase_q == PH_ADDR) && hready;
  assign dack       = (phase_q == PH_DATA) && hready;
  assign derr_first = (phase_q == PH_DATA) && hresp && !hready;
  assign derr       = hresp;
  assign rdata      = hrdata;
  assign haddr      = haddr_q;
  assign htrans     = htrans_q;
  assign hwrite     = hwrite_q;
  assign hwdata     = hwdata_q;

endmodule

// File: rtl/ahblite_dma_master.sv
// Single-channel AHB-Lite word-copy DMA: one read then one write per word.
// Define DMA_IRQ_EN to add the sticky irq output with irq_clr input.
module ahblite_dma_master
  import ahblite_dma_master_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 16,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          err_addr,
`ifdef DMA_IRQ_EN
  input  logic                 irq_clr,
  output logic                 irq,
`endif
  output logic [31:0]          HADDR,
  output logic [2:0]           HBURST,
  output logic                 HMASTLOCK,
  output logic [3:0]           HPROT,
  output logic [2:0]           HSIZE,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [31:0]          HWDATA,
  input  logic                 HREADY,
  input  logic [31:0]          HRDATA,
  input  logic                 HRESP
);

  dma_state_e           state_q, state_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [31:0]          err_addr_q, err_addr_d;

  logic        req, req_we;
  logic [31:0] req_addr;
  logic        aack, dack, derr_first, derr;
  logic [31:0] rdata;

  ahblite_master_if u_if (
    .clk        (HCLK),
    .rst        (HRESET),
    .req        (req),
    .we         (req_we),
    .addr       (req_addr),
    .wdata      (data_q),
    .aack       (aack),
    .dack       (dack),
    .derr_first (derr_first),
    .derr       (derr),
    .rdata      (rdata),
    .haddr      (HADDR),
    .htrans     (HTRANS),
    .hwrite     (HWRITE),
    .hwdata     (HWDATA),
    .hready     (HREADY),
    .hrdata     (HRDATA),
    .hresp      (HRESP)
  );

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    req        = 1'b0;
    req_we     = 1'b0;
    req_addr   = src_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          src_d  = word_align(src_addr);
          dst_d  = word_align(dst_addr);
          cnt_d  = len;
          err_d  = 1'b0;
          busy_d = 1'b1;
          if (len == '0) begin
            state_d = S_FIN;
          end else begin
            state_d  = S_RA;
            req      = 1'b1;
            req_addr = word_align(src_addr);
          end
        end
      end
      S_RA, S_WA: begin
        if (aack) state_d = (state_q == S_RA) ? S_RD : S_WD;
      end
      S_RD, S_WD: begin
        if (derr_first) begin
          err_d      = 1'b1;
          err_addr_d = HADDR;
        end
        if (dack) begin
          if (derr) begin
            state_d = S_FIN;
          end else if (state_q == S_RD) begin
            data_d   = rdata;
            src_d    = src_q + 32'd4;
            state_d  = S_WA;
            req      = 1'b1;
            req_we   = 1'b1;
            req_addr = dst_q;
          end else begin
            dst_d = dst_q + 32'd4;
            cnt_d = cnt_q - LEN_WIDTH'(1);
            if (cnt_q == LEN_WIDTH'(1)) begin
              state_d = S_FIN;
            end else begin
              state_d  = S_RA;
              req      = 1'b1;
              req_addr = src_q;
            end
          end
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef DMA_IRQ_EN
  logic irq_q, irq_d;

  // Holding the set term through the visible done cycle lets set beat clear
  always_comb begin
    irq_d = irq_q;
    if (irq_clr) irq_d = 1'b0;
    if (done_d || done_q) irq_d = 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VAL;
  assign HSIZE     = HSIZE_WORD;

endmodule
